// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mac_sequencer
//  Description : Feeds signed operand pairs to a sequential multiplier and
//                sums the sign-extended products into a saturating signed
//                accumulator. The sum is emitted when the last pair is done.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_sequencer #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40
) (
    input  logic                   clk94,
    input  logic                   rst94,
    input  logic                   in_valid94,
    output logic                   in_ready94,
    input  logic [WIDTH-1:0]       in_a94,
    input  logic [WIDTH-1:0]       in_b94,
    input  logic                   in_last94,
    output logic                   mul_start94,
    output logic [WIDTH-1:0]       mul_multiplier94,
    output logic [WIDTH-1:0]       mul_multiplicand94,
    input  logic                   mul_ready94,
    input  logic [2*WIDTH-1:0]     mul_product94,
    output logic                   out_valid94,
    input  logic                   out_ready94,
    output logic [ACC_WIDTH-1:0]   out_data94,
    output logic                   out_sat94
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_OUT       = 3'd4
    } state_t;

    localparam logic [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_last;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_sat;

    logic                   w_accept;
    logic                   w_capture;
    logic                   w_release;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_ovf;
    logic [ACC_WIDTH-1:0]   w_acc_next;

    // Operands go straight from the holding registers so they stay frozen
    // until the product is captured (the multiplier reads signs at the end).
    assign mul_multiplier94   = r_a;
    assign mul_multiplicand94 = r_b;

    assign w_accept  = in_valid94 && in_ready94;
    assign w_capture = (r_state == S_WAIT_DONE) && mul_ready94;
    assign w_release = (r_state == S_OUT) && out_ready94;

    // One guard bit: both operands sign-extended to ACC_WIDTH+1 before adding;
    // overflow shows up as the two top bits disagreeing.
    assign w_sum = {r_acc[ACC_WIDTH-1], r_acc}
                 + {{(ACC_WIDTH+1-2*WIDTH){mul_product94[2*WIDTH-1]}}, mul_product94};
    assign w_ovf = w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1];
    assign w_acc_next = w_ovf ? (w_sum[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX)
                              : w_sum[ACC_WIDTH-1:0];

    // State register
    always_ff @(posedge clk94) begin
        if (rst94) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake/control outputs
    always_comb begin
        w_state_next = r_state;
        in_ready94   = 1'b0;
        mul_start94  = 1'b0;
        out_valid94  = 1'b0;
        out_data94   = '0;
        out_sat94    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready94 = !rst94;
                if (in_valid94 && !rst94) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Never start a multiplier that is still busy.
                mul_start94 = mul_ready94;
                if (mul_ready94) begin
                    w_state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!mul_ready94) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (mul_ready94) begin
                    w_state_next = r_last ? S_OUT : S_IDLE;
                end
            end
            S_OUT: begin
                out_valid94 = 1'b1;
                out_data94  = r_acc;
                out_sat94   = r_sat;
                if (out_ready94) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand holding registers, accumulator and sticky saturation flag
    always_ff @(posedge clk94) begin
        if (rst94) begin
            r_a    <= '0;
            r_b    <= '0;
            r_last <= 1'b0;
            r_acc  <= '0;
            r_sat  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= in_a94;
                r_b    <= in_b94;
                r_last <= in_last94;
            end
            if (w_capture) begin
                r_acc <= w_acc_next;
                if (w_ovf) begin
                    r_sat <= 1'b1;
                end
            end
            if (w_release) begin
                r_acc <= '0;
                r_sat <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_sequencer
//  Description : Directed self-checking bench for mac_sequencer with a
//                behavioural 16-cycle sequential multiplier. A 40-bit and a
//                32-bit accumulator instance share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;

    localparam int W = 16;

    logic               clk94 = 1'b0;
    logic               rst94;
    logic               in_valid94;
    logic [W-1:0]       in_a94;
    logic [W-1:0]       in_b94;
    logic               in_last94;
    logic               out_ready94;
    logic               mul_ready94;
    logic [2*W-1:0]     mul_product94;

    logic               in_ready94, mul_start94, out_valid94, out_sat94;
    logic [W-1:0]       mul_multiplier94, mul_multiplicand94;
    logic [39:0]        out_data94;

    logic               in_ready32, mul_start32, out_valid32, out_sat32;
    logic [W-1:0]       mul_multiplier32, mul_multiplicand32;
    logic [31:0]        out_data32;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk94 = ~clk94;

    always @(posedge clk94) cyc <= cyc + 1;

    mac_sequencer #(.WIDTH(W), .ACC_WIDTH(40)) dut (
        .clk94(clk94), .rst94(rst94),
        .in_valid94(in_valid94), .in_ready94(in_ready94),
        .in_a94(in_a94), .in_b94(in_b94), .in_last94(in_last94),
        .mul_start94(mul_start94),
        .mul_multiplier94(mul_multiplier94), .mul_multiplicand94(mul_multiplicand94),
        .mul_ready94(mul_ready94), .mul_product94(mul_product94),
        .out_valid94(out_valid94), .out_ready94(out_ready94),
        .out_data94(out_data94), .out_sat94(out_sat94)
    );

    mac_sequencer #(.WIDTH(W), .ACC_WIDTH(32)) dut32 (
        .clk94(clk94), .rst94(rst94),
        .in_valid94(in_valid94), .in_ready94(in_ready32),
        .in_a94(in_a94), .in_b94(in_b94), .in_last94(in_last94),
        .mul_start94(mul_start32),
        .mul_multiplier94(mul_multiplier32), .mul_multiplicand94(mul_multiplicand32),
        .mul_ready94(mul_ready94), .mul_product94(mul_product94),
        .out_valid94(out_valid32), .out_ready94(out_ready94),
        .out_data94(out_data32), .out_sat94(out_sat32)
    );

    // Behavioural multiplier: busy for W cycles after start, product formed
    // from the operands present at completion. It is not reset by rst94.
    logic               m_busy = 1'b0;
    int                 m_cnt  = 0;
    logic               start_busy_err = 1'b0;
    logic signed [31:0] ea, eb;
    assign ea = 32'($signed(mul_multiplier94));
    assign eb = 32'($signed(mul_multiplicand94));
    assign mul_ready94 = !m_busy;

    always @(posedge clk94) begin
        if (mul_start94 && m_busy) start_busy_err <= 1'b1;
        if (mul_start94 && !m_busy) begin
            m_busy <= 1'b1;
            m_cnt  <= W;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy        <= 1'b0;
                mul_product94 <= ea * eb;
            end
        end
    end

    task automatic tick();
        @(posedge clk94);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one pair once the block is ready; returns the accept cycle.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic last, output int t);
        int n = 0;
        while (!in_ready94 && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_wait", 64'(in_ready94), 64'd1);
        in_valid94 = 1'b1;
        in_a94     = a;
        in_b94     = b;
        in_last94  = last;
        tick();
        t = cyc;
        in_valid94 = 1'b0;
    endtask

    task automatic wait_out(output int t);
        int n = 0;
        while (!out_valid94 && n < 100) begin
            tick();
            n++;
        end
        check("out_valid_wait", 64'(out_valid94), 64'd1);
        t = cyc;
    endtask

    task automatic handshake();
        out_ready94 = 1'b1;
        tick();
        out_ready94 = 1'b0;
    endtask

    initial begin
        int t0, t1, t2, t3, n;

        rst94       = 1'b1;
        in_valid94  = 1'b0;
        in_a94      = '0;
        in_b94      = '0;
        in_last94   = 1'b0;
        out_ready94 = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_in_ready",  64'(in_ready94),  64'd0);
        check("rst_mul_start", 64'(mul_start94), 64'd0);
        check("rst_out_valid", 64'(out_valid94), 64'd0);
        check("rst_out_data",  64'(out_data94),  64'd0);
        check("rst_out_sat",   64'(out_sat94),   64'd0);
        check("rst_mul_a",     64'(mul_multiplier94), 64'd0);
        rst94 = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready94), 64'd1);

        // 1: single pair 3 * -5
        send(16'sd3, -16'sd5, 1'b1, t0);
        check("t1_busy_in_ready", 64'(in_ready94),  64'd0);
        check("t1_issue_start",   64'(mul_start94), 64'd1);
        wait_out(t1);
        check("t1_latency", 64'(t1 - t0), 64'd18);
        check("t1_data40",  64'(out_data94), 64'hFF_FFFF_FFF1);
        check("t1_data32",  64'(out_data32), 64'hFFFF_FFF1);
        check("t1_sat",     64'(out_sat94),  64'd0);
        handshake();
        check("t1_released", 64'(out_valid94), 64'd0);

        // 2: four-pair batch, out_ready already high before OUT
        out_ready94 = 1'b1;
        send(16'sd100, 16'sd200, 1'b0, t0);
        check("t2_gap_ready", 64'(in_ready94), 64'd0);
        send(-16'sd300, 16'sd7, 1'b0, t1);
        check("t2_space1", 64'(t1 - t0), 64'd19);
        send(16'sh8000, 16'sh8000, 1'b0, t2);
        check("t2_space2", 64'(t2 - t1), 64'd19);
        send(16'sd1, -16'sd1, 1'b1, t3);
        check("t2_space3", 64'(t3 - t2), 64'd19);
        wait_out(t0);
        check("t2_data40", 64'(out_data94), 64'd1073759723);
        check("t2_data32", 64'(out_data32), 64'd1073759723);
        check("t2_sat",    64'(out_sat94),  64'd0);
        tick();
        check("t2_one_out_cycle", 64'(out_valid94), 64'd0);
        out_ready94 = 1'b0;

        // 3: three max-magnitude products saturate only the 32-bit instance
        send(16'sh8000, 16'sh8000, 1'b0, t0);
        send(16'sh8000, 16'sh8000, 1'b0, t0);
        send(16'sh8000, 16'sh8000, 1'b1, t0);
        wait_out(t0);
        check("t3_data40", 64'(out_data94), 64'd3221225472);
        check("t3_sat40",  64'(out_sat94),  64'd0);
        check("t3_data32", 64'(out_data32), 64'h7FFF_FFFF);
        check("t3_sat32",  64'(out_sat32),  64'd1);
        handshake();
        send(16'sd2, 16'sd3, 1'b1, t0);
        wait_out(t0);
        check("t3b_data40", 64'(out_data94), 64'd6);
        check("t3b_data32", 64'(out_data32), 64'd6);
        check("t3b_sat32",  64'(out_sat32),  64'd0);
        handshake();

        // 4: result held stable under back-pressure
        send(-16'sd7, 16'sd9, 1'b1, t0);
        wait_out(t0);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", 64'(out_valid94), 64'd1);
            check("t4_hold_data",  64'(out_data94),  64'hFF_FFFF_FFC1);
            check("t4_hold_sat",   64'(out_sat94),   64'd0);
            check("t4_hold_ready", 64'(in_ready94),  64'd0);
            tick();
        end
        handshake();
        send(16'sd4, 16'sd4, 1'b1, t0);
        wait_out(t0);
        check("t4_next_data", 64'(out_data94), 64'd16);
        handshake();

        // 5: reset in WAIT_DONE mid-multiply discards the partial sum
        send(16'sd1000, 16'sd1000, 1'b0, t0);
        send(16'sd10, 16'sd10, 1'b0, t0);
        tick();
        tick();
        check("t5_mul_busy", 64'(mul_ready94), 64'd0);
        rst94 = 1'b1;
        tick();
        check("t5_rst_in_ready",  64'(in_ready94),  64'd0);
        check("t5_rst_mul_start", 64'(mul_start94), 64'd0);
        check("t5_rst_out_valid", 64'(out_valid94), 64'd0);
        check("t5_rst_out_data",  64'(out_data94),  64'd0);
        check("t5_rst_mul_b",     64'(mul_multiplicand94), 64'd0);
        rst94 = 1'b0;
        send(16'sd5, 16'sd6, 1'b1, t0);
        n = 0;
        while (!mul_ready94 && n < 40) begin
            check("t5_stall_no_start", 64'(mul_start94), 64'd0);
            tick();
            n++;
        end
        check("t5_stall_seen",   64'(n > 0),       64'd1);
        check("t5_start_issued", 64'(mul_start94), 64'd1);
        wait_out(t0);
        check("t5_data40", 64'(out_data94), 64'd30);
        check("t5_data32", 64'(out_data32), 64'd30);
        handshake();

        // 6: valid held with changing data while busy; operands must hold
        in_valid94 = 1'b1;
        in_a94     = 16'sd7;
        in_b94     = 16'sd8;
        in_last94  = 1'b1;
        tick();
        n = 0;
        while (!out_valid94 && n < 40) begin
            in_a94    = W'($urandom);
            in_b94    = W'($urandom);
            in_last94 = 1'($urandom);
            check("t6_hold_a", 64'(mul_multiplier94),   64'd7);
            check("t6_hold_b", 64'(mul_multiplicand94), 64'd8);
            tick();
            n++;
        end
        in_valid94 = 1'b0;
        check("t6_out_valid", 64'(out_valid94), 64'd1);
        check("t6_data",      64'(out_data94),  64'd56);
        check("t6_busy_ready", 64'(in_ready94), 64'd0);
        handshake();
        check("t6_idle_ready", 64'(in_ready94), 64'd1);
        tick();
        check("t6_no_extra_accept", 64'(in_ready94),  64'd1);
        check("t6_no_extra_start",  64'(mul_start94), 64'd0);

        check("no_start_while_busy", 64'(start_busy_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
